// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the serial 7-segment display link sink
//
// Holds the bit positions of the four link wires in the sin bus and the
// display geometry (digit count and bits per digit).
package seg7_pkg;

  // Position of each link wire inside the 4-bit sin bus.
  localparam int SIN_SCLK = 3;
  localparam int SIN_CLRN = 2;
  localparam int SIN_DAT  = 1;
  localparam int SIN_EN   = 0;

  // Display geometry: one byte of segment pattern per digit.
  localparam int DIGITS         = 8;
  localparam int BITS_PER_DIGIT = 8;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchroniser with history FF and edge pulses
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   din   in   asynchronous input wire
//   level out  synchronised level (second stage)
//   rise  out  one-cycle pulse on a synchronised 0->1 transition
//   fall  out  one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sr[0], sr[1] form the synchroniser; sr[2] is the history stage used
  // only for edge detection.
  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {3{RST_VAL}};
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/seg7_serial_sink.sv
// rtl/seg7_serial_sink.sv - serial display link receiver and 8-digit 7-segment scanner
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   sin[3:0]    in   link: [3]=sclk, [2]=sclrn (active-low clear), [1]=sdat, [0]=sen (latch)
//   pdata       out  last correctly latched frame (WIDTH bits)
//   frame_valid out  one-cycle pulse when a frame latches
//   frame_err   out  one-cycle pulse when a latch arrives with a wrong bit count
//   segment     out  active-low segment lines of the selected digit
//   anode       out  active-low one-hot digit select
module seg7_serial_sink
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int SCAN_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sin,
  output logic [WIDTH-1:0] pdata,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [7:0]       segment,
  output logic [7:0]       anode
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(WIDTH);

  logic [3:0] sin_level;
  logic [3:0] sin_rise;
  logic [3:0] sin_fall;

  // sclrn idles high, so its synchroniser resets high to avoid a spurious
  // clear right after reset.
  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync_edge #(
      .RST_VAL (logic'(i == SIN_CLRN))
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (sin[i]),
      .level (sin_level[i]),
      .rise  (sin_rise[i]),
      .fall  (sin_fall[i])
    );
  end

  logic sclk_rise;
  logic sen_rise;
  logic clrn;
  logic sdat;

  assign sclk_rise = sin_rise[SIN_SCLK];
  assign sen_rise  = sin_rise[SIN_EN];
  assign clrn      = sin_level[SIN_CLRN];
  assign sdat      = sin_level[SIN_DAT];

  logic link_unused;
  assign link_unused = &{sin_fall, sin_rise[SIN_CLRN], sin_rise[SIN_DAT],
                         sin_level[SIN_SCLK], sin_level[SIN_EN]};

  // ---------------------------------------------------------------------
  // Shifter / latch
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic             have_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bitcnt      <= '0;
      pdata       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      have_frame  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!clrn) begin
        // Clear wins over both shift and latch; pdata keeps the last frame.
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        if (sclk_rise) begin
          shreg <= {shreg[WIDTH-2:0], sdat};
        end
        if (sen_rise) begin
          // Latch sees the pre-shift shreg/bitcnt; a bit shifted in the
          // same cycle becomes the first bit of the next frame.
          if (bitcnt == CW'(WIDTH)) begin
            pdata       <= shreg;
            frame_valid <= 1'b1;
            have_frame  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          bitcnt <= sclk_rise ? CW'(1) : CW'(0);
        end else if (sclk_rise && (bitcnt != CW'(WIDTH + 1))) begin
          // Saturating at WIDTH+1 keeps overrun distinguishable from a
          // full frame.
          bitcnt <= bitcnt + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------------
  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic [PW-1:0] base;

  assign base = PW'({digit, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
      segment  <= 8'hFF;
      anode    <= 8'hFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      // Registered from the current digit, so outputs follow a digit change
      // by one clock and pick up new pdata without restarting the scan.
      if (have_frame) begin
        anode   <= ~(8'b1 << digit);
        segment <= ~pdata[base +: BITS_PER_DIGIT];
      end else begin
        anode   <= 8'hFF;
        segment <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_serial_sink.sv
// tb/tb_seg7_serial_sink.sv - self-checking bench for seg7_serial_sink
module tb_seg7_serial_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        sclk = 1'b0;
  logic        sclrn = 1'b1;
  logic        sdat = 1'b0;
  logic        sen = 1'b0;
  logic [3:0]  sin;

  logic [63:0] pdata, pdata2;
  logic        frame_valid, frame_err, fv2, fe2;
  logic [7:0]  segment, anode, segment2, anode2;

  assign sin = {sclk, sclrn, sdat, sen};

  always #5 clk = ~clk;

  seg7_serial_sink #(.WIDTH(64), .SCAN_DIV(1024)) u_dut (
    .clk (clk), .rst (rst), .sin (sin),
    .pdata (pdata), .frame_valid (frame_valid), .frame_err (frame_err),
    .segment (segment), .anode (anode)
  );

  seg7_serial_sink #(.WIDTH(64), .SCAN_DIV(4)) u_scan (
    .clk (clk), .rst (rst2), .sin (sin),
    .pdata (pdata2), .frame_valid (fv2), .frame_err (fe2),
    .segment (segment2), .anode (anode2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int last_valid_cyc = 0;
  int sen_cyc = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  localparam logic [63:0] FA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FC = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] FD = 64'h5555_AAAA_3333_CCCC;
  localparam logic [63:0] FB = 64'hA5C3_1E78_0F96_D24B;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_valid) begin
      obs_q.push_back(pdata);
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) nerr++;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdat = v[i];
      repeat (8) tick();
      sclk = 1'b1;
      repeat (8) tick();
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_sen(input logic expect_ok, input logic [63:0] expv);
    if (expect_ok) exp_q.push_back(expv);
    sen_cyc = cyc;
    sen = 1'b1;
    repeat (8) tick();
    sen = 1'b0;
    repeat (8) tick();
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_pdata"}, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] walk [0:8];
  int v0, e0, lat;

  initial begin
    walk[0] = 8'hFE; walk[1] = 8'hFD; walk[2] = 8'hFB; walk[3] = 8'hF7;
    walk[4] = 8'hEF; walk[5] = 8'hDF; walk[6] = 8'hBF; walk[7] = 8'h7F;
    walk[8] = 8'hFE;

    // Reset and idle
    repeat (5) tick();
    rst = 1'b0;
    rst2 = 1'b0;
    repeat (100) tick();
    check("idle_pdata", pdata, 64'h0);
    check("idle_anode", 64'(anode), 64'hFF);
    check("idle_segment", 64'(segment), 64'hFF);
    check("idle_valid_cnt", 64'(nvalid), 64'd0);
    check("idle_err_cnt", 64'(nerr), 64'd0);

    // Full frame
    send_bits(128'(FA), 64);
    v0 = nvalid; e0 = nerr;
    pulse_sen(1'b1, FA);
    lat = last_valid_cyc - sen_cyc;
    check("fa_valid_pulses", 64'(nvalid - v0), 64'd1);
    check("fa_latency_ok", 64'(lat >= 3 && lat <= 4), 64'd1);
    check("fa_no_err", 64'(nerr - e0), 64'd0);
    compare_frames("fa");
    for (int i = 0; i < 9000; i++) begin
      if (anode == 8'hFE) break;
      tick();
    end
    check("fa_anode_d0", 64'(anode), 64'hFE);
    check("fa_segment_d0", 64'(segment), 64'h10);

    // Short frame then overrun frame
    send_bits(128'(FB), 63);
    v0 = nvalid; e0 = nerr;
    pulse_sen(1'b0, 64'h0);
    check("short_err", 64'(nerr - e0), 64'd1);
    check("short_no_valid", 64'(nvalid - v0), 64'd0);
    check("short_pdata_kept", pdata, FA);
    send_bits({64'h1, FB}, 65);
    v0 = nvalid; e0 = nerr;
    pulse_sen(1'b0, 64'h0);
    check("over_err", 64'(nerr - e0), 64'd1);
    check("over_no_valid", 64'(nvalid - v0), 64'd0);
    check("over_pdata_kept", pdata, FA);
    compare_frames("errs");

    // Mid-frame clear then full frame
    send_bits(128'(FD), 30);
    sclrn = 1'b0;
    repeat (5) tick();
    sclrn = 1'b1;
    repeat (8) tick();
    check("clr_pdata_kept", pdata, FA);
    send_bits(128'(FC), 64);
    e0 = nerr;
    pulse_sen(1'b1, FC);
    check("clr_no_err", 64'(nerr - e0), 64'd0);
    compare_frames("clr");

    // Simultaneous sclk and sen edges
    send_bits(128'(FD), 64);
    sdat = FB[63];
    repeat (8) tick();
    exp_q.push_back(FD);
    sclk = 1'b1;
    sen = 1'b1;
    repeat (8) tick();
    sclk = 1'b0;
    sen = 1'b0;
    repeat (8) tick();
    send_bits(128'(FB), 63);
    e0 = nerr;
    pulse_sen(1'b1, FB);
    check("simul_no_err", 64'(nerr - e0), 64'd0);
    compare_frames("simul");

    // Fast scanner walk
    for (int i = 0; i < 64; i++) begin
      if (anode2 == 8'hFE) break;
      tick();
    end
    check("walk_0", 64'(anode2), 64'(walk[0]));
    check("walk_seg_d0", 64'(segment2), 64'hB4);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) tick();
      check("walk_hold", 64'(anode2), 64'(walk[k-1]));
      tick();
      check($sformatf("walk_%0d", k), 64'(anode2), 64'(walk[k]));
    end

    // Asynchronous reset mid-scan
    repeat (2) tick();
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    check("arst_anode", 64'(anode2), 64'hFF);
    check("arst_segment", 64'(segment2), 64'hFF);
    check("arst_pdata", pdata2, 64'h0);
    repeat (2) tick();
    rst2 = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
